// File: rtl/spike_network.sv
// spike_network: round-robin selector that broadcasts one spiking neuron per
// network phase, scanning a shadow copy of the spike vector one lane per cycle.
`default_nettype none

module spike_network #(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 256,
  parameter int NEURON_ID_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_NEURON-1:0]                     en_network,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]      spike_vec,
  input  logic [NEURON_ID_WIDTH-1:0]                active_neuron,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
  output logic                                      networkDone,
  output logic [15:0]                               flip_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_NEURON-1:0][TEN_DATA_WIDTH-1:0] shadow;
  logic [NEURON_ID_WIDTH-1:0]                n_lat;
  logic [NEURON_ID_WIDTH-1:0]                idx;
  logic [NEURON_ID_WIDTH-1:0]                idx_inc;
  logic [NEURON_ID_WIDTH-1:0]                rr_ptr;
  logic [NEURON_ID_WIDTH-1:0]                scan_cnt;
  logic                                      armed;

  logic [NUM_NEURON-1:0]     lane_active;
  logic                      all_en;
  logic                      trigger;
  logic [TEN_DATA_WIDTH-1:0] code;
  logic                      is_spike;
  logic                      last_lane;

  // Only lanes below active_neuron take part in the trigger handshake.
  always_comb begin
    lane_active = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      lane_active[i] = (i < int'(active_neuron));
    end
  end

  assign all_en    = &(en_network | ~lane_active);
  assign trigger   = (state == IDLE) && armed && (active_neuron != '0) && all_en;
  assign code      = shadow[idx];
  assign is_spike  = (code == TEN_DATA_WIDTH'(1)) || (code == TEN_DATA_WIDTH'(2));
  assign idx_inc   = ((idx + 1'b1) == n_lat) ? '0 : idx + 1'b1;
  assign last_lane = (scan_cnt == n_lat - 1'b1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trigger) state_nx = SCAN;
      SCAN:    if (is_spike || last_lane) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      spike_in    <= '0;
      networkDone <= 1'b0;
      flip_count  <= '0;
      rr_ptr      <= '0;
      idx         <= '0;
      scan_cnt    <= '0;
      n_lat       <= '0;
      armed       <= 1'b1;
      shadow      <= '0;
    end else begin
      state       <= state_nx;
      networkDone <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (trigger) begin
            shadow   <= spike_vec;
            n_lat    <= active_neuron;
            idx      <= (rr_ptr >= active_neuron) ? '0 : rr_ptr;
            scan_cnt <= '0;
            armed    <= 1'b0;
          end else if (!all_en) begin
            // Requests must drop before the next phase can start.
            armed <= 1'b1;
          end
        end
        SCAN: begin
          if (is_spike) begin
            spike_in <= {code, idx};
            rr_ptr   <= idx_inc;
            if (flip_count != 16'hFFFF) flip_count <= flip_count + 16'd1;
          end else if (last_lane) begin
            spike_in <= '0;
          end else begin
            idx      <= idx_inc;
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spike_network.sv
// Directed self-checking bench for spike_network.
`default_nettype none

module tb_spike_network;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] en_network;
  logic [511:0] spike_vec;
  logic [7:0]   active_neuron;
  logic [9:0]   spike_in;
  logic         networkDone;
  logic [15:0]  flip_count;

  int total = 0;
  int bad   = 0;

  spike_network dut (
    .clk          (clk),
    .reset        (reset),
    .en_network   (en_network),
    .spike_vec    (spike_vec),
    .active_neuron(active_neuron),
    .spike_in     (spike_in),
    .networkDone  (networkDone),
    .flip_count   (flip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Drop requests for one IDLE cycle, raise them, and measure the latency:
  // the first edge after raising is edge T, so the edge count equals n in T+n.
  task automatic run_round(input string tag, input int exp_lat,
                           input logic [9:0] exp_spk, input logic [15:0] exp_fc);
    int e;
    en_network = '0;
    @(posedge clk); #1;
    en_network = '1;
    e = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      e++;
      if (networkDone) break;
    end
    if (!networkDone) e = -1;
    chk({tag, "_lat"}, e, exp_lat);
    chk({tag, "_spk"}, {22'd0, spike_in}, {22'd0, exp_spk});
    chk({tag, "_fc"}, {16'd0, flip_count}, {16'd0, exp_fc});
    @(posedge clk); #1;
    chk({tag, "_pulse1"}, {31'd0, networkDone}, 32'd0);
    chk({tag, "_hold"}, {22'd0, spike_in}, {22'd0, exp_spk});
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (networkDone) p++;
    end
  endtask

  initial begin
    int p;
    reset         = 1'b1;
    en_network    = '0;
    spike_vec     = '0;
    active_neuron = 8'd4;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_spk", {22'd0, spike_in}, 32'd0);
    chk("rst_done", {31'd0, networkDone}, 32'd0);
    chk("rst_fc", {16'd0, flip_count}, 32'd0);
    reset = 1'b0;

    // Lanes 0..3 = {0,0,2,1}; lane 5 spiking but outside the active range.
    spike_vec[7:0]   = 8'h60;
    spike_vec[11:10] = 2'd1;
    run_round("a", 4, 10'h202, 16'd1);

    // Requests held high: no second phase until they drop.
    count_pulses(6, p);
    chk("no_retrig", p, 0);

    run_round("b", 2, 10'h103, 16'd2);
    run_round("c", 4, 10'h202, 16'd3);

    // Reset in the middle of a scan of an empty vector.
    spike_vec  = '0;
    en_network = '0;
    @(posedge clk); #1;
    en_network = '1;
    @(posedge clk); @(posedge clk); #1;
    reset      = 1'b1;
    en_network = '0;
    @(posedge clk); #1;
    chk("mid_done", {31'd0, networkDone}, 32'd0);
    chk("mid_spk", {22'd0, spike_in}, 32'd0);
    chk("mid_fc", {16'd0, flip_count}, 32'd0);
    reset = 1'b0;
    count_pulses(6, p);
    chk("mid_nopulse", p, 0);

    // All lanes null or invalid: full scan, zero broadcast.
    spike_vec[7:0] = 8'h33;
    run_round("d", 5, 10'h000, 16'd0);

    // active_neuron = 0 never triggers, even when armed.
    en_network = '0;
    @(posedge clk); #1;
    active_neuron = 8'd0;
    en_network    = '1;
    count_pulses(8, p);
    chk("zero_act", p, 0);
    active_neuron = 8'd4;

    // Round-robin pointer restarts at 0 after reset.
    spike_vec[7:0] = 8'h60;
    run_round("e", 4, 10'h202, 16'd1);

    // Saturation: preload near the top, then two more selections.
    force dut.flip_count = 16'hFFFE;
    #1;
    release dut.flip_count;
    spike_vec[7:0] = 8'h55;
    run_round("f", 2, 10'h103, 16'hFFFF);
    run_round("g", 2, 10'h100, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
